// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: rising edges of valid push char into a small FIFO,
// and a bit-timing FSM drains it onto uart_tx with back-to-back frames when data is queued.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 100,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          char,
  input  logic                valid,
  input  logic                clr_ovf,
  output logic                uart_tx,
  output logic                busy,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [15:0]         DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [7:0]            shift;
  logic [2:0]            bit_cnt;
  logic [15:0]           div_cnt;
  logic                  valid_q;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  div_done;

  assign push     = valid & ~valid_q;
  assign div_done = (div_cnt == DIV_LAST);
  // Pops happen only where the FSM enters START: from IDLE, or at the end of a STOP bit.
  assign pop      = (count != '0) && ((state == IDLE) || ((state == STOP) && div_done));
  assign full     = (count == CNT_FULL);
  assign accept   = push & (~full | pop);
  assign busy     = (state != IDLE) | (count != '0);

  // valid_q follows valid even in reset, so a strobe held across reset release is not an edge.
  // NOTE: registers are updated with non-blocking assignments so every always_ff sees pre-edge values.
  always_ff @(posedge clk) valid_q <= valid;

  // NOTE: storage has no reset; the pointers and count alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push outranks a simultaneous clear.
      if (push && !accept) overflow <= 1'b1;
      else if (clr_ovf)    overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      div_cnt <= div_done ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          div_cnt <= '0;
          if (pop) begin
            shift   <= mem[rd_ptr];
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (div_done) begin
            bit_cnt <= '0;
            uart_tx <= shift[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (div_done) begin
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end
        end
        STOP: begin
          if (div_done) begin
            if (pop) begin
              shift   <= mem[rd_ptr];
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue/frame-countdown model for the main instance,
// plus line-log decoding for a second, minimal-size instance.
module tb_uart_tx_fifo;

  localparam int DIV_A   = 4;
  localparam int DL_A    = 2;
  localparam int DEPTH_A = 4;
  localparam int DIV_B   = 2;
  localparam int DL_B    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     = 1'b1;
  logic          valid   = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [7:0]    ch_a    = 8'h00;
  logic          tx_a, busy_a, full_a, ovf_a;
  logic [DL_A:0] count_a;

  logic          valid_b = 1'b0;
  logic          clr_b   = 1'b0;
  logic [7:0]    ch_b    = 8'h00;
  logic          tx_b, busy_b, full_b, ovf_b;
  logic [DL_B:0] count_b;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(.CLK_DIV(DIV_A), .DEPTH_LOG2(DL_A)) dut_a (
    .clk(clk), .rst(rst), .char(ch_a), .valid(valid), .clr_ovf(clr_ovf),
    .uart_tx(tx_a), .busy(busy_a), .full(full_a), .count(count_a), .overflow(ovf_a)
  );

  uart_tx_fifo #(.CLK_DIV(DIV_B), .DEPTH_LOG2(DL_B)) dut_b (
    .clk(clk), .rst(rst), .char(ch_b), .valid(valid_b), .clr_ovf(clr_b),
    .uart_tx(tx_b), .busy(busy_b), .full(full_b), .count(count_b), .overflow(ovf_b)
  );

  logic [6:0] dut_vec;
  assign dut_vec = {tx_a, busy_a, full_a, ovf_a, count_a};

  // Reference model: a queue of pending characters and a countdown of the frame on the line.
  logic [7:0] m_q[$];
  int         m_left = 0;
  logic [7:0] m_cur  = 8'h00;
  logic       m_ovf  = 1'b0;
  logic       m_prev = 1'b0;
  logic       log_b[$];

  task automatic model_step();
    bit pushed, popped, dropped;
    int pre;
    if (rst) begin
      m_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
      m_prev = valid;
      return;
    end
    pre    = m_q.size();
    pushed = valid && !m_prev;
    m_prev = valid;
    if (m_left > 0) m_left--;
    popped  = (m_left == 0) && (pre != 0);
    dropped = pushed && (pre == DEPTH_A) && !popped;
    if (popped) begin
      m_cur  = m_q.pop_front();
      m_left = 10 * DIV_A;
    end
    if (pushed && !dropped) m_q.push_back(ch_a);
    if (dropped) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  function automatic logic [6:0] exp_vec();
    int   pos;
    logic tx;
    if (m_left == 0) tx = 1'b1;
    else begin
      pos = (10 * DIV_A - m_left) / DIV_A;
      if (pos == 0)      tx = 1'b0;
      else if (pos == 9) tx = 1'b1;
      else               tx = m_cur[pos-1];
    end
    return {tx, (m_left != 0) || (m_q.size() != 0), m_q.size() == DEPTH_A, m_ovf, 3'(m_q.size())};
  endfunction

  // Advance one clock; the model sees the same pre-edge inputs as the DUTs, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    log_b.push_back(tx_b);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; valid_b = 1'b0; clr_ovf = 1'b0; clr_b = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec !== 7'b1000000) begin
        failures++;
        $display("FAIL reset_a cyc=%0d dut={tx,busy,full,ovf,count}=%b expected=1000000", i, dut_vec);
      end
      checks++;
      if ({tx_b, busy_b, full_b, ovf_b, count_b} !== 6'b100000) begin
        failures++;
        $display("FAIL reset_b cyc=%0d dut=%b expected=100000", i, {tx_b, busy_b, full_b, ovf_b, count_b});
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push_55();
    ch_a = 8'h55; valid = 1'b1;
    tick();
    checks++;
    if (count_a !== 3'd1 || tx_a !== 1'b1) begin
      failures++;
      $display("FAIL push55_e0 count=%0d tx=%b expected count=1 tx=1", count_a, tx_a);
    end
    valid = 1'b0;
    tick();
    checks++;
    if (tx_a !== 1'b0 || count_a !== 3'd0) begin
      failures++;
      $display("FAIL push55_start tx=%b count=%0d expected tx=0 count=0", tx_a, count_a);
    end
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL push55_frame cyc=%0d dut=%b expected=%b", i, dut_vec, exp_vec());
      end
      if (i == 39) begin
        checks++;
        if (busy_a !== 1'b1) begin
          failures++;
          $display("FAIL push55_busy39 busy=%b expected=1", busy_a);
        end
      end
    end
    checks++;
    if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
      failures++;
      $display("FAIL push55_end busy=%b tx=%b expected busy=0 tx=1", busy_a, tx_a);
    end
  endtask

  task automatic test_held_valid();
    int peak = 0;
    ch_a = 8'hA3; valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) valid = 1'b0;
      tick();
      if (int'(count_a) > peak) peak = int'(count_a);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL held_frame cyc=%0d dut=%b expected=%b", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (peak != 1 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL held_once peak=%0d busy=%b expected peak=1 busy=0", peak, busy_a);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      ch_a = 8'(k); valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
    end
    checks++;
    if (count_a !== 3'd4 || full_a !== 1'b1 || ovf_a !== 1'b1) begin
      failures++;
      $display("FAIL ovf_fill count=%0d full=%b ovf=%b expected count=4 full=1 ovf=1", count_a, full_a, ovf_a);
    end
    // A dropped push on the same edge as clr_ovf must leave the flag set.
    ch_a = 8'h07; valid = 1'b1; clr_ovf = 1'b1;
    tick();
    valid = 1'b0; clr_ovf = 1'b0;
    checks++;
    if (ovf_a !== 1'b1 || count_a !== 3'd4) begin
      failures++;
      $display("FAIL ovf_set_wins ovf=%b count=%0d expected ovf=1 count=4", ovf_a, count_a);
    end
    for (int i = 0; i < 220; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL ovf_drain cyc=%0d dut=%b expected=%b", i, dut_vec, exp_vec());
      end
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (ovf_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear ovf=%b busy=%b expected ovf=0 busy=0", ovf_a, busy_a);
    end
  endtask

  task automatic test_full_pop();
    int budget = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ch_a = 8'h10 + 8'(k); valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
    end
    while (!(m_left == 1 && m_q.size() == DEPTH_A) && budget < 200) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 200 || full_a !== 1'b1) begin
      failures++;
      $display("FAIL fullpop_setup budget=%0d full=%b expected full=1 before stop end", budget, full_a);
    end
    ch_a = 8'h9C; valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (count_a !== 3'd4 || ovf_a !== 1'b0 || tx_a !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_edge count=%0d ovf=%b tx=%b expected count=4 ovf=0 tx=0", count_a, ovf_a, tx_a);
    end
    for (int i = 0; i < 210; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL fullpop_drain cyc=%0d dut=%b expected=%b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ch_a = 8'(8'hC0 + k); valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
    end
    // Land inside data bit 3 (frame position 4) with two characters still queued.
    while (m_left != 22 && budget < 100) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 100 || count_a !== 3'd2) begin
      failures++;
      $display("FAIL rstmid_setup budget=%0d count=%0d expected count=2", budget, count_a);
    end
    rst = 1'b1; valid = 1'b1; ch_a = 8'hEE;
    tick();
    checks++;
    if (tx_a !== 1'b1 || count_a !== 3'd0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_edge tx=%b count=%0d busy=%b expected tx=1 count=0 busy=0", tx_a, count_a, busy_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) valid = 1'b0;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rstmid_after cyc=%0d dut=%b expected=%b", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (dut_vec !== 7'b1000000) begin
      failures++;
      $display("FAIL rstmid_quiet dut=%b expected=1000000", dut_vec);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      valid   = ($urandom_range(0, 3) == 0);
      ch_a    = 8'($urandom);
      clr_ovf = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d dut=%b expected=%b", i, dut_vec, exp_vec());
      end
    end
    valid = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 220; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_drain cyc=%0d dut=%b expected=%b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_small_wrap();
    int         hi, lows, nfr, i;
    logic [7:0] exp_b[5];
    logic [7:0] d;
    do_reset();
    ch_b = 8'hFF; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    checks++;
    if (count_b !== 2'd1 || full_b !== 1'b0) begin
      failures++;
      $display("FAIL small_e0 count=%0d full=%b expected count=1 full=0", count_b, full_b);
    end
    tick();
    hi = 1; lows = (tx_b === 1'b0) ? 1 : 0;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (busy_b !== 1'b1) break;
      hi++;
      if (tx_b === 1'b0) lows++;
    end
    checks++;
    if (hi != 20 || lows != 2) begin
      failures++;
      $display("FAIL small_ff_frame busy_cycles=%0d low_cycles=%0d expected 20 and 2", hi, lows);
    end

    log_b.delete();
    for (int k = 0; k < 5; k++) exp_b[k] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      ch_b = exp_b[k]; valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      tick();
    end
    for (int j = 0; j < 70; j++) tick();
    for (int k = 3; k < 5; k++) begin
      ch_b = exp_b[k]; valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      tick();
    end
    for (int j = 0; j < 60; j++) tick();
    checks++;
    if (ovf_b !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL small_idle ovf=%b busy=%b expected ovf=0 busy=0", ovf_b, busy_b);
    end
    i = 0; nfr = 0;
    while (i + 19 < log_b.size()) begin
      if (log_b[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) d[k] = log_b[i + DIV_B * (k + 1)];
        checks++;
        if (nfr >= 5 || log_b[i + 18] !== 1'b1 || d !== exp_b[nfr]) begin
          failures++;
          $display("FAIL small_order frame=%0d got=%h stop=%b expected=%h", nfr, d, log_b[i + 18],
                   (nfr < 5) ? exp_b[nfr] : 8'h00);
        end
        nfr++;
        i += 10 * DIV_B;
      end else begin
        i++;
      end
    end
    checks++;
    if (nfr != 5) begin
      failures++;
      $display("FAIL small_frames got=%0d expected=5", nfr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push_55();
    test_held_valid();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    test_small_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
